// File: rtl/periph_pkg.sv
// Shared definitions for the board peripheral subsystem.
// Holds the default accumulator/LED width and debounce length, and the
// counter-width helper used by the debouncer.
package periph_pkg;

  localparam int DEFAULT_WIDTH           = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Width needed for a counter that must represent 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounce.sv
// Synchronizer + debouncer for one asynchronous, possibly bouncing input.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   raw    - raw asynchronous input
//   press  - one-cycle pulse on each debounced 1->0 transition of raw
// The synchronizer, debounced level and its delayed copy all reset to
// RESET_LEVEL (1 for an active-low button, i.e. "released").
module debounce
  import periph_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int               CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1, sync_2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the pre-edge values, which is what makes the 2-FF chain a chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1   <= RESET_LEVEL;
      sync_2   <= RESET_LEVEL;
      stable   <= RESET_LEVEL;
      stable_d <= RESET_LEVEL;
      cnt      <= '0;
    end else begin
      sync_1   <= raw;
      sync_2   <= sync_1;
      stable_d <= stable;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level; rising edges are ignored.
  assign press = stable_d & ~stable;

endmodule

// File: rtl/top.sv
// Board-level peripheral top: synchronizes the slide switches, debounces the
// active-low push button and adds a step to a WIDTH-bit accumulator on every
// debounced press. The accumulator register drives the LEDs directly.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   switches - raw slide switches (asynchronous)
//   button   - raw push button, active-low, may bounce
//   leds     - accumulator value (registered)
module top
  import periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WIDTH           = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic             button,
  output logic [WIDTH-1:0] leds
);

  logic [WIDTH-1:0] sw_meta, sw_sync;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] step;
  logic             press;

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (button),
    .press (press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // All-zero switches would make a press invisible, so step by one instead.
  assign step = (sw_sync != '0) ? sw_sync : WIDTH'(1);

  // Addition wraps modulo 2^WIDTH; the carry is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (press) begin
      acc <= acc + step;
    end
  end

  assign leds = acc;

endmodule

// File: tb/tb_top.sv
module tb_top;

  localparam int D = 16;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] switches;
  logic         button;
  logic [W-1:0] leds;

  int n_cmp = 0;
  int n_bad = 0;

  top #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .button   (button),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. A level is accepted once the last D synchronized
  // samples all disagree with the current accepted level; a press is the
  // accepted level going 1->0, and it adds the switch value (or 1) one
  // cycle later.
  // ---------------------------------------------------------------------
  bit         m_b1, m_b2, m_stable, m_stable_d;
  int         m_sw1, m_sw2, m_acc;
  bit [D-1:0] m_hist;

  function automatic bit all_differ(input bit [D-1:0] h, input bit s);
    return s ? (h == '0) : (h == '1);
  endfunction

  function automatic int step_of(input int sw);
    return (sw != 0) ? sw : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_b1 <= 1; m_b2 <= 1; m_stable <= 1; m_stable_d <= 1;
      m_sw1 <= 0; m_sw2 <= 0; m_acc <= 0;
      m_hist <= '1;
    end else begin
      if (m_stable_d && !m_stable) m_acc <= (m_acc + step_of(m_sw2)) % (1 << W);
      m_stable_d <= m_stable;
      m_hist     <= {m_hist[D-2:0], m_b2};
      if (all_differ({m_hist[D-2:0], m_b2}, m_stable)) m_stable <= m_b2;
      m_b2  <= m_b1;
      m_b1  <= button;
      m_sw2 <= m_sw1;
      m_sw1 <= int'(switches);
    end
  end

  // Continuous cycle-by-cycle comparison against the model.
  bit model_on = 0;
  always @(negedge clk) begin
    if (model_on) check("leds_vs_model", int'(leds), m_acc);
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------
  task automatic hold(input bit level, input int cycles);
    @(negedge clk);
    button = level;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic press(input int low_cycles, input int high_cycles);
    hold(1'b0, low_cycles);
    hold(1'b1, high_cycles);
  endtask

  // Press and measure edges between the first low sample and the LED update.
  task automatic timed_press(input string tag);
    logic [W-1:0] prev;
    int n;
    @(negedge clk);
    prev   = leds;
    button = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (leds == prev && n < 200);
    check(tag, n - 1, D + 2);
    repeat (80) @(negedge clk);
    hold(1'b1, 100);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_immediate", int'(leds), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  initial begin
    reset    = 1'b0;
    button   = 1'b1;
    switches = '0;
    @(negedge clk);
    check("reset_state", int'(leds), 0);
    reset    = 1'b1;
    model_on = 1;

    // Idle after reset.
    repeat (1000) @(negedge clk);
    check("idle_1000", int'(leds), 0);

    // Two clean presses with switches = 0, latency measured.
    timed_press("latency_press1");
    check("clean_press1", int'(leds), 1);
    timed_press("latency_press2");
    check("clean_press2", int'(leds), 2);

    // Bounce: ten short low/high pulses then a solid press.
    for (int i = 0; i < 10; i++) begin
      hold(1'b0, 5);
      hold(1'b1, 5);
    end
    check("bounce_no_event", int'(leds), 2);
    press(100, 100);
    check("bounce_one_event", int'(leds), 3);

    // Switch step with wrap.
    pulse_reset();
    switches = 10'd300;
    repeat (5) @(negedge clk);
    press(100, 100);
    check("step_300", int'(leds), 300);
    press(100, 100);
    check("step_600", int'(leds), 600);
    switches = 10'd500;
    repeat (5) @(negedge clk);
    press(100, 100);
    check("step_wrap_76", int'(leds), 76);

    // Held button: one increment; switch changes while held are ignored.
    switches = 10'd5;
    repeat (5) @(negedge clk);
    hold(1'b0, 1000);
    check("held_once", int'(leds), 81);
    switches = 10'd123;
    hold(1'b0, 1000);
    check("held_switch_change", int'(leds), 81);
    hold(1'b1, 100);
    check("held_release", int'(leds), 81);

    // Reset during the debounce window of a press; button released with it.
    switches = 10'd7;
    hold(1'b0, 8);
    @(negedge clk);
    #2;
    reset  = 1'b0;
    button = 1'b1;
    #1;
    check("reset_mid_debounce", int'(leds), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("no_event_after_reset", int'(leds), 0);

    // Randomized segments checked against the model every cycle.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) switches = W'($urandom);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    hold(1'b1, 50);
    check("random_final", int'(leds), m_acc);

    model_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/top.md
# top

Board-level peripheral subsystem: synchronizes the slide switches and an active-low push button, debounces the button, and accumulates a 10-bit value on each debounced press, driving it onto the LEDs. It is the top of the design, with ports mapped directly to board pins.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- WIDTH, default 10: width of switches, accumulator and LEDs.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- switches  input  10  raw slide switches, asynchronous to clk.
- button  input  1  raw push button, active-low (1 = released, 0 = pressed), asynchronous, may bounce.
- leds  output  10  registered accumulator value.

## Operation
- Switch synchronizer: 2-FF per bit → sw_sync.
- Button synchronizer: 2-FF → btn_sync.
- Debouncer holds `stable` and a counter:
  - btn_sync == stable → counter cleared.
  - Otherwise the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, `stable` takes btn_sync and the counter clears.
- Press detect: `stable_d` is `stable` delayed one cycle. press = stable_d & ~stable, a one-cycle pulse on each debounced 1→0 transition. Release (0→1) produces no event.
- Accumulator acc[9:0]:
  - On press: acc ← acc + step, where step = sw_sync if sw_sync ≠ 0, else 1.
  - Addition is modulo 2^10: 1023 + 1 wraps to 0; carry discarded.
  - sw_sync is the value sampled in the press cycle.
- leds = acc. This is a direct register output, with no combinational path from inputs.
- Held button: exactly one press event. Bounce or glitches shorter than DEBOUNCE_CYCLES cycles: no event.

## Timing
- Reset (reset = 0, asynchronous):
  - acc = 0, leds = 0.
  - Button sync FFs, `stable` and `stable_d` = 1.
  - Switch sync FFs = 0; counter = 0.
  - Release is synchronous to clk by construction. The first edge after release resumes normal operation.
- Latency: button low first captured at edge k.
  - btn_sync = 0 after edge k+1.
  - `stable` flips at edge k+1+DEBOUNCE_CYCLES.
  - leds update at edge k+2+DEBOUNCE_CYCLES, i.e. 19 edges inclusive for the default.
- Switch changes reach sw_sync after 2 edges. Changes do not affect leds until the next press.
- Reset asserted mid-debounce or mid-press: all state cleared immediately; no pending event survives.
- Back-to-back presses: each needs a debounced release (≥ DEBOUNCE_CYCLES high) followed by a debounced press.

## Structure
- Shared package `periph_pkg`:
  - WIDTH default.
  - DEBOUNCE_CYCLES default.
  - Counter width as $clog2(DEBOUNCE_CYCLES+1).
- Sub-module `debounce`:
  - Ports: clk, reset, raw input.
  - Contains the 2-FF synchronizer, counter, `stable` and the press pulse output.
  - Parameterized by DEBOUNCE_CYCLES and reset level.
- `top` holds the switch synchronizer, accumulator and LED register.

## Test plan
- Reset: reset = 0 for 1 cycle with button = 1, switches = 0 → leds = 0; leds hold 0 for 1000 cycles after release.
- Two clean presses: switches = 0; each press is button = 0 for 100 cycles, separated by 100 cycles high → leds = 1 after the first press, 2 after the second. Each update lands exactly DEBOUNCE_CYCLES+2 edges after the first low sample.
- Bounce rejection: pulses low for 5 cycles then high for 5 cycles, repeated 10×, then held low for 100 cycles → exactly one increment.
- Switch step: switches = 10'd300, leds = 0, two presses → leds = 300, then 600. Third press with switches = 10'd500 → 1100 mod 1024 = 76 (wrap).
- Held button: button low for 2000 cycles → a single increment. Changing switches while held leaves leds unchanged.
- Async reset mid-operation: reset pulsed low during the debounce window of a press → leds = 0 immediately, and no increment follows for that press.
